// File: rtl/logic_pattern_gen.sv
// rtl/logic_pattern_gen.sv - multi-mode logic pattern generator with rate divider and burst control
module logic_pattern_gen #(
   parameter int                       SAMP_CHANNELS = 8,
   parameter int                       DIV_WIDTH     = 16,
   parameter int                       LEN_WIDTH     = 16,
   parameter logic [SAMP_CHANNELS-1:0] LFSR_TAPS     = SAMP_CHANNELS'(8'hB8)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   input  logic                     stop_i,
   input  logic [1:0]               mode_i,
   input  logic [DIV_WIDTH-1:0]     div_i,
   input  logic [LEN_WIDTH-1:0]     len_i,
   output logic [SAMP_CHANNELS-1:0] data_o,
   output logic                     strobe_o,
   output logic                     busy_o,
   output logic                     done_o
);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t                   state_q, state_d;
   logic [SAMP_CHANNELS-1:0] data_q, data_d;
   logic [SAMP_CHANNELS-1:0] gray_q, gray_d;
   logic                     strobe_q, strobe_d;
   logic                     done_q, done_d;
   logic [1:0]               mode_q, mode_d;
   logic [DIV_WIDTH-1:0]     div_q, div_d;
   logic [DIV_WIDTH-1:0]     presc_q, presc_d;
   logic [LEN_WIDTH-1:0]     len_q, len_d;
   logic [LEN_WIDTH-1:0]     cnt_q, cnt_d;

   logic [SAMP_CHANNELS-1:0] seed;
   logic [SAMP_CHANNELS-1:0] step_data;
   logic [SAMP_CHANNELS-1:0] step_gray;

   assign data_o   = data_q;
   assign strobe_o = strobe_q;
   assign busy_o   = (state_q == ST_RUN);
   assign done_o   = done_q;

   // Seed for the pattern requested at start (uses the live mode input, not the latched one)
   always_comb begin
      seed = '0;
      case (mode_i)
         2'd1:    seed = SAMP_CHANNELS'(1);
         2'd2:    seed = '1;
         default: seed = '0;
      endcase
   end

   // Next pattern value for one step in the latched mode; Gray mode steps its hidden binary counter
   always_comb begin
      step_data = data_q;
      step_gray = gray_q;
      case (mode_q)
         2'd0:    step_data = data_q + 1'b1;
         2'd1:    step_data = {data_q[SAMP_CHANNELS-2:0], data_q[SAMP_CHANNELS-1]};
         2'd2:    step_data = data_q[0] ? ((data_q >> 1) ^ LFSR_TAPS) : (data_q >> 1);
         default: begin
            step_gray = gray_q + 1'b1;
            step_data = step_gray ^ (step_gray >> 1);
         end
      endcase
   end

   // Burst FSM: start loads seed, prescaler paces steps, length or stop ends the burst
   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      gray_d   = gray_q;
      strobe_d = 1'b0;
      done_d   = 1'b0;
      mode_d   = mode_q;
      div_d    = div_q;
      len_d    = len_q;
      presc_d  = presc_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d  = ST_RUN;
               mode_d   = mode_i;
               div_d    = div_i;
               len_d    = len_i;
               data_d   = seed;
               gray_d   = '0;
               strobe_d = 1'b1;
               cnt_d    = LEN_WIDTH'(1);
               presc_d  = '0;
            end
         end
         default: begin
            // stop wins over a due step; the final sample of a finite burst ends it too
            if (stop_i || ((len_q != '0) && (cnt_q == len_q))) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else if (presc_q == div_q) begin
               presc_d  = '0;
               data_d   = step_data;
               gray_d   = step_gray;
               strobe_d = 1'b1;
               if (cnt_q != '1) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
      endcase
   end

   // State register with asynchronous clear
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         data_q   <= '0;
         gray_q   <= '0;
         strobe_q <= 1'b0;
         done_q   <= 1'b0;
         mode_q   <= '0;
         div_q    <= '0;
         len_q    <= '0;
         presc_q  <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         gray_q   <= gray_d;
         strobe_q <= strobe_d;
         done_q   <= done_d;
         mode_q   <= mode_d;
         div_q    <= div_d;
         len_q    <= len_d;
         presc_q  <= presc_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_logic_pattern_gen.sv
// tb/tb_logic_pattern_gen.sv - self-checking bench for logic_pattern_gen
module tb_logic_pattern_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic        stop_i;
   logic [1:0]  mode_i;
   logic [15:0] div_i;
   logic [15:0] len_i;
   logic [7:0]  data_o;
   logic        strobe_o;
   logic        busy_o;
   logic        done_o;

   int          vectors = 0;
   int          errors  = 0;
   logic [7:0]  lfsr_tab [255];
   logic [7:0]  seen_q [$];

   always #5 clk = ~clk;

   logic_pattern_gen dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .start_i  (start_i),
      .stop_i   (stop_i),
      .mode_i   (mode_i),
      .div_i    (div_i),
      .len_i    (len_i),
      .data_o   (data_o),
      .strobe_o (strobe_o),
      .busy_o   (busy_o),
      .done_o   (done_o)
   );

   // Value of the k-th sample of a burst (k = 0 is the seed)
   function automatic logic [7:0] pat(input int m, input int k);
      logic [7:0] g;
      case (m)
         0:       return 8'(k % 256);
         1:       return 8'(1 << (k % 8));
         2:       return lfsr_tab[k % 255];
         default: begin
            g = 8'(k % 256);
            return g ^ (g >> 1);
         end
      endcase
   endfunction

   // Start a burst at the next edge and check every cycle against the ideal timeline
   task automatic run_burst(input int m, input int d, input int l, input int s, input int tail);
      int         e, el, k;
      logic [7:0] exp_d;
      logic       exp_s, exp_b, exp_n;
      el = (l != 0) ? (l - 1) * (d + 1) + 1 : (1 << 30);
      e  = (s != 0 && s < el) ? s : el;
      seen_q.delete();
      mode_i  = 2'(m);
      div_i   = 16'(d);
      len_i   = 16'(l);
      start_i = 1'b1;
      stop_i  = 1'b0;
      for (int t = 0; t <= e + tail; t++) begin
         @(negedge clk);
         if (t < e) begin
            k     = t / (d + 1);
            exp_s = ((t % (d + 1)) == 0);
            exp_b = 1'b1;
            exp_n = 1'b0;
            exp_d = pat(m, k);
         end else begin
            exp_s = 1'b0;
            exp_b = 1'b0;
            exp_n = (t == e);
            exp_d = pat(m, (e - 1) / (d + 1));
         end
         if (strobe_o === 1'b1) seen_q.push_back(data_o);
         vectors++;
         if ({strobe_o, busy_o, done_o, data_o} !== {exp_s, exp_b, exp_n, exp_d}) begin
            errors++;
            $display("FAIL burst m=%0d d=%0d l=%0d t=%0d: got strobe/busy/done/data=%b/%b/%b/%h expected %b/%b/%b/%h",
                     m, d, l, t, strobe_o, busy_o, done_o, data_o, exp_s, exp_b, exp_n, exp_d);
         end
         start_i = (t + 1 < e) ? 1'($urandom_range(0, 1)) : 1'b0;
         stop_i  = (s != 0 && t + 1 == s);
         mode_i  = 2'($urandom);
         div_i   = 16'($urandom);
         len_i   = 16'($urandom);
      end
      start_i = 1'b0;
      stop_i  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1 rst = 1'b1;
      #2;
      vectors++;
      if ({strobe_o, busy_o, done_o, data_o} !== 11'd0) begin
         errors++;
         $display("FAIL reset_async: got strobe/busy/done/data=%b/%b/%b/%h expected 0/0/0/00",
                  strobe_o, busy_o, done_o, data_o);
      end
      repeat (2) @(negedge clk);
      vectors++;
      if ({strobe_o, busy_o, done_o, data_o} !== 11'd0) begin
         errors++;
         $display("FAIL reset_held: got strobe/busy/done/data=%b/%b/%b/%h expected 0/0/0/00",
                  strobe_o, busy_o, done_o, data_o);
      end
      rst = 1'b0;
   endtask

   task automatic test_counter();
      run_burst(0, 0, 4, 0, 2);
   endtask

   task automatic test_walking();
      run_burst(1, 2, 9, 0, 2);
   endtask

   task automatic test_lfsr();
      logic [255:0] map;
      int           distinct;
      run_burst(2, 0, 256, 0, 1);
      map      = '0;
      distinct = 0;
      for (int i = 0; i < 255 && i < seen_q.size(); i++) begin
         if (seen_q[i] != 8'h00 && !map[seen_q[i]]) distinct++;
         map[seen_q[i]] = 1'b1;
      end
      vectors++;
      if (distinct != 255) begin
         errors++;
         $display("FAIL lfsr_distinct: got %0d distinct nonzero values expected 255", distinct);
      end
      vectors++;
      if (seen_q.size() != 256 || seen_q[255] !== 8'hFF) begin
         errors++;
         $display("FAIL lfsr_sample256: got size %0d last %h expected size 256 last ff",
                  seen_q.size(), (seen_q.size() > 0) ? seen_q[seen_q.size()-1] : 8'h00);
      end
   endtask

   task automatic test_gray();
      int bad;
      run_burst(3, 0, 0, 300, 2);
      bad = 0;
      for (int i = 1; i < seen_q.size(); i++) begin
         if ($countones(seen_q[i] ^ seen_q[i-1]) != 1) bad++;
      end
      vectors++;
      if (bad != 0 || seen_q.size() != 300) begin
         errors++;
         $display("FAIL gray_adjacent: got %0d bad pairs over %0d samples expected 0 over 300",
                  bad, seen_q.size());
      end
      vectors++;
      if (seen_q.size() < 257 || seen_q[255] !== 8'h80 || seen_q[256] !== 8'h00) begin
         errors++;
         $display("FAIL gray_wrap: got samples 255/256 not 80/00 (size %0d)", seen_q.size());
      end
   endtask

   task automatic test_stop_on_step();
      run_burst(0, 4, 0, 10, 2);
   endtask

   task automatic test_stop_idle();
      logic [7:0] held;
      held   = data_o;
      stop_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         stop_i = 1'b0;
         vectors++;
         if ({strobe_o, busy_o, done_o, data_o} !== {3'b000, held}) begin
            errors++;
            $display("FAIL stop_idle cyc=%0d: got strobe/busy/done/data=%b/%b/%b/%h expected 0/0/0/%h",
                     i, strobe_o, busy_o, done_o, data_o, held);
         end
      end
   endtask

   task automatic test_back_to_back();
      run_burst(1, 1, 3, 0, 0);
      run_burst(3, 0, 5, 0, 0);
      run_burst(0, 2, 2, 0, 2);
   endtask

   task automatic test_random();
      int m, d, l, s;
      for (int i = 0; i < 8; i++) begin
         m = $urandom_range(0, 3);
         d = $urandom_range(0, 3);
         l = $urandom_range(0, 12);
         s = ($urandom_range(0, 1) == 1 || l == 0) ? $urandom_range(1, 30) : 0;
         run_burst(m, d, l, s, $urandom_range(0, 2));
      end
   endtask

   task automatic test_async_reset();
      mode_i  = 2'd0;
      div_i   = 16'd1;
      len_i   = 16'd0;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (6) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({strobe_o, busy_o, done_o, data_o} !== 11'd0) begin
         errors++;
         $display("FAIL midburst_reset: got strobe/busy/done/data=%b/%b/%b/%h expected 0/0/0/00",
                  strobe_o, busy_o, done_o, data_o);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if ({strobe_o, busy_o, done_o, data_o} !== 11'd0) begin
            errors++;
            $display("FAIL post_reset cyc=%0d: got strobe/busy/done/data=%b/%b/%b/%h expected 0/0/0/00",
                     i, strobe_o, busy_o, done_o, data_o);
         end
      end
      run_burst(2, 1, 6, 0, 2);
   endtask

   initial begin
      start_i = 1'b0;
      stop_i  = 1'b0;
      mode_i  = 2'd0;
      div_i   = 16'd0;
      len_i   = 16'd0;
      lfsr_tab[0] = 8'hFF;
      for (int i = 1; i < 255; i++) begin
         lfsr_tab[i] = lfsr_tab[i-1][0] ? ((lfsr_tab[i-1] >> 1) ^ 8'hB8) : (lfsr_tab[i-1] >> 1);
      end
      test_reset();
      test_counter();
      test_walking();
      test_lfsr();
      test_gray();
      test_stop_on_step();
      test_stop_idle();
      test_back_to_back();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
